// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-bus transaction at a time, stalls upstream
// until it completes, then registers the aligned/extended write-back payload.
module mem_access_stage #(
  parameter bit KSEG_UNMAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_res,
  input  logic        mem_data_en,
  input  logic [3:0]  mem_data_ren,
  input  logic [3:0]  mem_data_wen,
  input  logic [31:0] mem_wdata,
  input  logic        mem_loadX,
  input  logic        mem_regwen,
  input  logic [5:0]  mem_wreg,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic        wb_regwen,
  output logic [5:0]  wb_wreg,
  output logic [31:0] wb_wdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  lane_mask;
  logic [2:0]  nbytes;
  logic [31:0] vaddr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        complete;

  // Request fields are pure functions of the held EX/MEM inputs, so they stay
  // stable for as long as the stall keeps those inputs frozen.
  assign lane_mask  = mem_data_ren | mem_data_wen;
  assign nbytes     = {2'b00, lane_mask[0]} + {2'b00, lane_mask[1]}
                    + {2'b00, lane_mask[2]} + {2'b00, lane_mask[3]};
  assign data_wr    = |mem_data_wen;
  assign data_wstrb = mem_data_wen;
  assign data_wdata = mem_wdata;

  always_comb begin
    case (nbytes)
      3'd1:    data_size = 2'd0;
      3'd2:    data_size = 2'd1;
      default: data_size = 2'd2;
    endcase
  end

  always_comb begin
    vaddr = (data_size == 2'd2) ? {mem_res[31:2], 2'b00} : mem_res;
    if (KSEG_UNMAP && vaddr[31:30] == 2'b10)
      data_addr = {3'b000, vaddr[28:0]};
    else
      data_addr = vaddr;
  end

  always_comb begin
    case (mem_res[1:0])
      2'd0:    byte_sel = data_rdata[7:0];
      2'd1:    byte_sel = data_rdata[15:8];
      2'd2:    byte_sel = data_rdata[23:16];
      default: byte_sel = data_rdata[31:24];
    endcase
    half_sel = mem_res[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (data_size)
      2'd0:    load_data = {{24{~mem_loadX & byte_sel[7]}}, byte_sel};
      2'd1:    load_data = {{16{~mem_loadX & half_sel[15]}}, half_sel};
      default: load_data = data_rdata;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    data_req  = 1'b0;
    mem_stall = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_data_en) begin
          data_req  = 1'b1;
          mem_stall = 1'b1;
          state_nxt = data_addr_ok ? WAIT : REQ;
        end else begin
          complete = 1'b1;
        end
      end
      REQ: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
        if (data_addr_ok) state_nxt = WAIT;
      end
      WAIT: begin
        if (data_data_ok) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences the bus and releases the pipeline in the same cycle.
    if (reset) begin
      data_req  = 1'b0;
      mem_stall = 1'b0;
      complete  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_pc     <= '0;
      wb_regwen <= 1'b0;
      wb_wreg   <= '0;
      wb_wdata  <= '0;
    end else if (complete) begin
      wb_valid  <= 1'b1;
      wb_pc     <= mem_pc;
      wb_regwen <= mem_regwen;
      wb_wreg   <= mem_wreg;
      wb_wdata  <= (state == WAIT && !data_wr) ? load_data : mem_res;
    end else begin
      wb_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// ALU/load/store traffic compared against a byte-level reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_pc, mem_res, mem_wdata, data_rdata;
  logic        mem_data_en, mem_loadX, mem_regwen;
  logic [3:0]  mem_data_ren, mem_data_wen;
  logic [5:0]  mem_wreg;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        mem_stall, wb_valid, wb_regwen;
  logic [31:0] wb_pc, wb_wdata;
  logic [5:0]  wb_wreg;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.KSEG_UNMAP(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mem_pc(mem_pc), .mem_res(mem_res), .mem_data_en(mem_data_en),
    .mem_data_ren(mem_data_ren), .mem_data_wen(mem_data_wen),
    .mem_wdata(mem_wdata), .mem_loadX(mem_loadX), .mem_regwen(mem_regwen),
    .mem_wreg(mem_wreg),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_regwen(wb_regwen), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] res, input logic [3:0] mask);
    logic [31:0] a;
    a = res;
    if ($countones(mask) == 4) a = a & 32'hFFFF_FFFC;
    if (a[31:30] == 2'b10) a = a & 32'h1FFF_FFFF;
    return a;
  endfunction

  function automatic logic [1:0] model_size(input logic [3:0] mask);
    int n;
    n = $countones(mask);
    return (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
  endfunction

  // Shift the addressed lane down, keep n bytes, then extend from the top kept bit.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [3:0] mask, input logic loadx);
    int n;
    logic [31:0] v, keep;
    n = $countones(mask);
    if (n == 4) return rdata;
    v    = rdata >> (8 * off);
    keep = (32'h1 << (8 * n)) - 32'h1;
    v    = v & keep;
    if (!loadx && v[8*n-1]) v = v | ~keep;
    return v;
  endfunction

  task automatic alu_op(input logic [31:0] pc, input logic [31:0] res,
                        input logic regwen, input logic [5:0] wreg);
    mem_pc = pc; mem_res = res; mem_regwen = regwen; mem_wreg = wreg;
    mem_data_en = 1'b0; mem_data_ren = 4'h0; mem_data_wen = 4'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
    #1;
    check("alu_req", data_req, 0);
    check("alu_stall", mem_stall, 0);
    @(negedge clk); #1;
    check("alu_wb_valid", wb_valid, 1);
    check("alu_wb_pc", wb_pc, pc);
    check("alu_wb_regwen", wb_regwen, regwen);
    check("alu_wb_wreg", wb_wreg, wreg);
    check("alu_wb_wdata", wb_wdata, res);
  endtask

  task automatic mem_txn(input logic [31:0] pc, input logic [31:0] res, input logic st,
                         input logic [3:0] mask, input logic [31:0] wdata, input logic loadx,
                         input logic regwen, input logic [5:0] wreg, input int addr_dly,
                         input int data_dly, input logic [31:0] rdata, input logic early);
    logic [31:0] exp_wb;
    int stalls;
    exp_wb = st ? res : model_load(rdata, res[1:0], mask, loadx);
    mem_pc = pc; mem_res = res; mem_wdata = wdata; mem_loadX = loadx;
    mem_regwen = regwen; mem_wreg = wreg; mem_data_en = 1'b1;
    mem_data_ren = st ? 4'h0 : mask;
    mem_data_wen = st ? mask : 4'h0;
    stalls = 0;
    for (int k = 0; k <= addr_dly; k++) begin
      data_addr_ok = (k == addr_dly);
      data_data_ok = early;
      data_rdata   = $urandom;
      #1;
      check("req", data_req, 1);
      check("addr", data_addr, model_addr(res, mask));
      check("size", 32'(data_size), 32'(model_size(mask)));
      check("wr", data_wr, st);
      check("wstrb", 32'(data_wstrb), st ? 32'(mask) : 32'h0);
      check("wdata", data_wdata, wdata);
      if (k > 0) check("bubble_req", wb_valid, 0);
      stalls += int'(mem_stall);
      @(negedge clk);
    end
    data_addr_ok = 1'b0;
    for (int k = 0; k <= data_dly; k++) begin
      data_data_ok = (k == data_dly);
      data_rdata   = (k == data_dly) ? rdata : $urandom;
      #1;
      check("wait_req", data_req, 0);
      check("bubble_wait", wb_valid, 0);
      if (k < data_dly) stalls += int'(mem_stall);
      else              check("release", mem_stall, 0);
      @(negedge clk);
    end
    data_data_ok = 1'b0;
    mem_data_en  = 1'b0;
    #1;
    check("stall_cycles", stalls, addr_dly + 1 + data_dly);
    check("wb_valid", wb_valid, 1);
    check("wb_pc", wb_pc, pc);
    check("wb_regwen", wb_regwen, regwen);
    check("wb_wreg", wb_wreg, wreg);
    check("wb_wdata", wb_wdata, exp_wb);
  endtask

  initial begin
    reset = 1'b1;
    mem_pc = 32'h0; mem_res = 32'h0; mem_wdata = 32'h0; mem_loadX = 1'b0;
    mem_regwen = 1'b1; mem_wreg = 6'd3; mem_data_en = 1'b1;
    mem_data_ren = 4'hF; mem_data_wen = 4'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_pc", wb_pc, 0);
    check("rst_wb_regwen", wb_regwen, 0);
    check("rst_wb_wreg", wb_wreg, 0);
    check("rst_wb_wdata", wb_wdata, 0);
    check("rst_req", data_req, 0);
    check("rst_stall", mem_stall, 0);
    reset = 1'b0;

    alu_op(32'h0000_0100, 32'h1234_5678, 1'b1, 6'd5);
    // LB from kseg0, sign-extended top lane, three stall cycles
    mem_txn(32'h104, 32'h8000_0003, 1'b0, 4'b1000, 32'h0, 1'b0, 1'b1, 6'd7,
            0, 2, 32'h80FF_FFFF, 1'b0);
    // LHU from kseg1, upper half
    mem_txn(32'h108, 32'hA000_0102, 1'b0, 4'b1100, 32'h0, 1'b1, 1'b1, 6'd8,
            0, 1, 32'hBEEF_1234, 1'b0);
    // SW with addr_ok held off three cycles
    mem_txn(32'h10C, 32'h0000_1000, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 6'd0,
            3, 1, 32'h0, 1'b0);
    // LW with data_ok asserted throughout REQ, which must be ignored
    mem_txn(32'h110, 32'h0000_2004, 1'b0, 4'b1111, 32'h0, 1'b0, 1'b1, 6'd9,
            2, 1, 32'h0BAD_CAFE, 1'b1);

    // Reset while in WAIT, then a late data_ok
    mem_pc = 32'h114; mem_res = 32'h0000_3000; mem_data_en = 1'b1;
    mem_data_ren = 4'hF; mem_data_wen = 4'h0; mem_regwen = 1'b1; mem_wreg = 6'd10;
    data_addr_ok = 1'b1; data_data_ok = 1'b0;
    @(negedge clk);
    data_addr_ok = 1'b0; reset = 1'b1;
    #1;
    check("rstw_req", data_req, 0);
    check("rstw_stall", mem_stall, 0);
    @(negedge clk);
    reset = 1'b0; mem_data_en = 1'b0; mem_regwen = 1'b0; mem_res = 32'h0000_0055;
    data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    #1;
    check("rstw_wb_valid", wb_valid, 0);
    check("rstw_late_stall", mem_stall, 0);
    check("rstw_late_req", data_req, 0);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    check("rstw_no_regwen", wb_regwen, 0);
    check("rstw_no_load_wb", wb_wdata, 32'h0000_0055);

    for (int i = 0; i < 40; i++) begin
      int kind, sz;
      logic [1:0]  off;
      logic [3:0]  mask;
      logic [31:0] r;
      kind = int'($urandom_range(0, 2));
      sz   = int'($urandom_range(0, 2));
      if (sz == 0)      off = 2'($urandom_range(0, 3));
      else if (sz == 1) off = 2'($urandom_range(0, 1)) << 1;
      else              off = 2'd0;
      mask = (sz == 0) ? (4'b0001 << off) : (sz == 1) ? (4'b0011 << off) : 4'b1111;
      r = $urandom;
      if ($urandom_range(0, 1) == 1) r[31:30] = 2'b10;
      r[1:0] = off;
      if (kind == 0)
        alu_op($urandom, r, 1'($urandom_range(0, 1)), 6'($urandom));
      else
        mem_txn($urandom, r, kind == 2, mask, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 6'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
